cmp_arbiter: RTL

- Shares one WIDTH-bit masked equality comparator (bitwise XNOR, AND-reduced) between up to four requesters, e.g. blitter source compare, blitter destination compare and the DSP.
- A round-robin arbiter grants one requester at a time and latches its operands.
- A three-state sequencer registers the XNOR result and returns it tagged with the requester index.
- Sits between the requesters and the compare datapath; the datapath is internal to this block.

---
 rtl/cmp_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin shared masked equality comparator
module cmp_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 3
) (
  input  logic                  MasterClock,
  input  logic                  nReset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ*WIDTH-1:0] mask_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_bits,
  output logic                  res_eq,
  output logic [1:0]            res_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       next_ptr;
  logic [2:0]       idx;
  logic [WIDTH-1:0] cmp;

  // Round-robin search: first asserted request starting at ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NREQ)) begin
        idx = idx - 3'(NREQ);
      end
      if (!found && req[idx[1:0]]) begin
        found = 1'b1;
        pick  = idx[1:0];
      end
    end
    next_ptr = (pick == 2'(NREQ - 1)) ? 2'd0 : pick + 2'd1;
  end

  // Masked equality of the latched operands
  always_comb begin
    cmp = ~(a_q ^ b_q) | m_q;
  end

  // Busy whenever a compare occupies the datapath
  always_comb begin
    busy = (state != IDLE);
  end

  // Sequencer: grant and latch in IDLE, evaluate in EVAL, present in DONE
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      id_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_bits  <= '0;
      res_eq    <= 1'b0;
      res_id    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= NREQ'(1) << pick;
            a_q   <= a_in[pick*WIDTH +: WIDTH];
            b_q   <= b_in[pick*WIDTH +: WIDTH];
            m_q   <= mask_in[pick*WIDTH +: WIDTH];
            id_q  <= pick;
            ptr   <= next_ptr;
            state <= EVAL;
          end
        end
        EVAL: begin
          res_bits  <= cmp;
          res_eq    <= &cmp;
          res_id    <= id_q;
          res_valid <= 1'b1;
          gnt       <= '0;
          state     <= DONE;
        end
        DONE: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt       <= '0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
